p66b_rx_sync: RTL and testbench

P66B_RX_SYNC -- requirements
Module: p66b_rx_sync

---
 rtl/p66b_rx_sync_pkg.sv | 30 +++
 rtl/p66b_rx_sync_descrambler.sv | 41 ++++
 rtl/p66b_rx_sync.sv | 142 ++++++++++++++
 tb/tb_p66b_rx_sync.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p66b_rx_sync_pkg.sv
// Shared 10GBASE-R receive definitions: block geometry, sync header codes,
// descrambler polynomial taps and the block-lock FSM state encoding.
package p66b_rx_sync_pkg;

  localparam int unsigned BLOCK_W   = 66;
  localparam int unsigned HDR_W     = 2;
  localparam int unsigned PAYLOAD_W = BLOCK_W - HDR_W;

  // Self-synchronous descrambler x^58 + x^39 + 1, state bit j = bit received j+1 ago
  localparam int unsigned SCR_W     = 58;
  localparam int unsigned SCR_TAP_A = 38;
  localparam int unsigned SCR_TAP_B = 57;

  localparam logic [HDR_W-1:0] HDR_DATA = 2'b01;
  localparam logic [HDR_W-1:0] HDR_CTRL = 2'b10;

  // Error-monitoring window length while locked
  localparam int unsigned WIN_LEN = 64;

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } lock_state_e;

  function automatic logic hdr_is_valid(input logic [HDR_W-1:0] hdr);
    return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
  endfunction

endpackage

// File: rtl/p66b_rx_sync_descrambler.sv
// p64bdescrambler: 64-bit self-synchronous descrambler (x^58 + x^39 + 1).
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset (clears state)
//   i_en           : a payload word is present; state advances only then
//   i_data         : scrambled payload, bit 0 received first
//   o_data         : descrambled payload (combinational from i_data/state)
module p64bdescrambler
  import p66b_rx_sync_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_en,
  input  logic [PAYLOAD_W-1:0] i_data,
  output logic [PAYLOAD_W-1:0] o_data
);

  logic [SCR_W-1:0] state_q;
  logic [SCR_W-1:0] state_d;

  // Bit-serial recurrence unrolled over the word; the history is fed with the
  // received (scrambled) bits, which is what makes the descrambler self-syncing.
  always_comb begin
    logic [SCR_W-1:0] s;
    s      = state_q;
    o_data = '0;
    for (int unsigned k = 0; k < PAYLOAD_W; k++) begin
      o_data[k] = i_data[k] ^ s[SCR_TAP_A] ^ s[SCR_TAP_B];
      s         = {s[SCR_W-2:0], i_data[k]};
    end
    state_d = s;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= '0;
    end else if (i_en) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/p66b_rx_sync.sv
// p66b_rx_sync: 64b/66b receive block-lock and descrambling.
// Hunts for sync-header alignment, requests bit slips from the upstream
// gearbox, monitors header errors once locked, and descrambles the payload.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_valid,i_data : received 66-bit block, [1:0] sync header
//   o_slip         : one-cycle bit-slip request (same cycle as offending word)
//   o_lock         : block lock
//   o_valid,o_data : descrambled block, one cycle latency, header unmodified
// SLIP_WAIT must be at least 1.
module p66b_rx_sync
  import p66b_rx_sync_pkg::*;
#(
  parameter int unsigned SLIP_WAIT = 4,
  parameter int unsigned LOCK_GOOD = 64,
  parameter int unsigned ERR_LIMIT = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [BLOCK_W-1:0] i_data,
  output logic               o_slip,
  output logic               o_lock,
  output logic               o_valid,
  output logic [BLOCK_W-1:0] o_data
);

  localparam int unsigned WAIT_W = (SLIP_WAIT < 2) ? 1 : $clog2(SLIP_WAIT);

  localparam logic [6:0]        GOOD_LAST = 7'(LOCK_GOOD - 1);
  localparam logic [5:0]        BAD_LAST  = 6'(ERR_LIMIT - 1);
  localparam logic [5:0]        WIN_LAST  = 6'(WIN_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  lock_state_e       state_q, state_d;
  logic [6:0]        good_q, good_d;
  logic [5:0]        win_q, win_d;
  logic [5:0]        bad_q, bad_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              slip_req;
  logic              hdr_ok;
  logic [PAYLOAD_W-1:0] descr_data;

  p64bdescrambler u_descr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (i_valid),
    .i_data  (i_data[BLOCK_W-1:HDR_W]),
    .o_data  (descr_data)
  );

  always_comb begin
    hdr_ok   = hdr_is_valid(i_data[HDR_W-1:0]);
    state_d  = state_q;
    good_d   = good_q;
    win_d    = win_q;
    bad_d    = bad_q;
    wait_d   = wait_q;
    slip_req = 1'b0;
    if (i_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (hdr_ok) begin
            if (good_q == GOOD_LAST) begin
              state_d = ST_LOCKED;
              good_d  = '0;
              win_d   = '0;
              bad_d   = '0;
            end else begin
              good_d = good_q + 7'd1;
            end
          end else begin
            slip_req = 1'b1;
            good_d   = '0;
            wait_d   = '0;
            state_d  = ST_SLIP_WAIT;
          end
        end
        ST_SLIP_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            wait_d  = '0;
            state_d = ST_HUNT;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        ST_LOCKED: begin
          // Loss of lock is tested before window end so it wins on word 64
          if (!hdr_ok && (bad_q == BAD_LAST)) begin
            slip_req = 1'b1;
            win_d    = '0;
            bad_d    = '0;
            wait_d   = '0;
            state_d  = ST_SLIP_WAIT;
          end else if (win_q == WIN_LAST) begin
            win_d = '0;
            bad_d = '0;
          end else begin
            win_d = win_q + 6'd1;
            if (!hdr_ok) begin
              bad_d = bad_q + 6'd1;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Mealy request; reset masks it so a reset cycle never slips the gearbox
  assign o_slip = slip_req && !i_reset;
  assign o_lock = (state_q == ST_LOCKED);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_HUNT;
      good_q  <= '0;
      win_q   <= '0;
      bad_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      win_q   <= win_d;
      bad_q   <= bad_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= i_valid && o_lock;
      if (i_valid) begin
        o_data <= {descr_data, i_data[HDR_W-1:0]};
      end
    end
  end

endmodule

// File: tb/tb_p66b_rx_sync.sv
module tb_p66b_rx_sync;

  localparam int SW = 4;
  localparam int LG = 64;
  localparam int EL = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [65:0] din = '0;
  logic        slip, lock, ovld;
  logic [65:0] dout;

  always #5 clk = ~clk;

  p66b_rx_sync #(.SLIP_WAIT(SW), .LOCK_GOOD(LG), .ERR_LIMIT(EL)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_valid (vld),
    .i_data  (din),
    .o_slip  (slip),
    .o_lock  (lock),
    .o_valid (ovld),
    .o_data  (dout)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 hunting, 1 waiting after slip, 2 locked
  int          m_mode, m_good, m_wait, m_win, m_bad;
  bit          hist[$];          // received scrambled bits, oldest first, last 58 kept
  logic [65:0] m_data;
  bit          m_valid;
  bit          e_slip;

  task automatic model_reset();
    m_mode = 0; m_good = 0; m_wait = 0; m_win = 0; m_bad = 0;
    hist.delete();
    for (int i = 0; i < 58; i++) hist.push_back(1'b0);
    m_data  = '0;
    m_valid = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit v, input logic [65:0] d);
    bit hv;
    bit was_lock;
    e_slip = 1'b0;
    if (r) begin
      model_reset();
      return;
    end
    was_lock = (m_mode == 2);
    m_valid  = v && was_lock;
    if (!v) return;
    for (int k = 0; k < 64; k++) begin
      bit in_b;
      in_b = d[k+2];
      // taps: bits received 39 and 58 positions earlier
      m_data[k+2] = in_b ^ hist[hist.size()-39] ^ hist[hist.size()-58];
      hist.push_back(in_b);
      void'(hist.pop_front());
    end
    m_data[1:0] = d[1:0];
    hv = (d[1:0] == 2'b01) || (d[1:0] == 2'b10);
    case (m_mode)
      0: begin
        if (hv) begin
          m_good++;
          if (m_good == LG) begin m_mode = 2; m_good = 0; m_win = 0; m_bad = 0; end
        end else begin
          e_slip = 1'b1; m_good = 0; m_wait = 0; m_mode = 1;
        end
      end
      1: begin
        m_wait++;
        if (m_wait == SW) begin m_mode = 0; m_wait = 0; end
      end
      default: begin
        int nb;
        nb = m_bad + (hv ? 0 : 1);
        if (nb == EL) begin
          e_slip = 1'b1; m_mode = 1; m_win = 0; m_bad = 0; m_wait = 0;
        end else if (m_win == 63) begin
          m_win = 0; m_bad = 0;
        end else begin
          m_win++; m_bad = nb;
        end
      end
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  bit obs_slip;
  int slip_seen;

  task automatic step(input bit r, input bit v, input logic [65:0] d);
    @(negedge clk);
    rst = r; vld = v; din = d;
    model_step(r, v, d);
    #1;
    obs_slip = slip;
    if (slip === 1'b1) slip_seen++;
    chk("o_slip", slip, e_slip);
    @(posedge clk);
    #1;
    chk("o_lock", lock, m_mode == 2);
    chk("o_valid", ovld, m_valid);
    chk("o_data", dout, m_data);
  endtask

  task automatic good_words(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, {64'h0, 2'b01});
  endtask

  task automatic bad_words(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, {64'h0, 2'b11});
  endtask

  logic [57:0] tx_s;

  task automatic scramble(input logic [63:0] p, output logic [63:0] s);
    for (int k = 0; k < 64; k++) begin
      s[k] = p[k] ^ tx_s[38] ^ tx_s[57];
      tx_s = {tx_s[56:0], s[k]};
    end
  endtask

  bit rxq[$];

  task automatic gen_block();
    logic [63:0] p, s;
    logic [65:0] blk;
    p = {$urandom, $urandom};
    scramble(p, s);
    blk = {s, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10};
    for (int k = 0; k < 66; k++) rxq.push_back(blk[k]);
  endtask

  typedef struct {
    bit         rst;
    int         n;
    bit         v;
    logic [1:0] hdr;
    bit         slip;
    bit         lock;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    slip_seen = 0;

    // {reset, repeat, valid, header, expected o_slip, expected o_lock after edge}
    tbl.push_back('{1, 1, 0, 2'b01, 0, 0});
    tbl.push_back('{0, 63, 1, 2'b01, 0, 0});
    tbl.push_back('{0, 1, 1, 2'b01, 0, 1});
    tbl.push_back('{0, 3, 1, 2'b01, 0, 1});
    tbl.push_back('{1, 1, 1, 2'b11, 0, 0});   // reset beats a bad valid word
    tbl.push_back('{0, 10, 1, 2'b01, 0, 0});
    tbl.push_back('{0, 2, 0, 2'b11, 0, 0});   // idle cycles ignore header
    tbl.push_back('{0, 1, 1, 2'b11, 1, 0});
    tbl.push_back('{0, 4, 1, 2'b11, 0, 0});   // discarded during wait
    tbl.push_back('{0, 1, 1, 2'b11, 1, 0});   // first word after wait is tested
    tbl.push_back('{0, 4, 1, 2'b00, 0, 0});
    tbl.push_back('{0, 63, 1, 2'b10, 0, 0});
    tbl.push_back('{0, 1, 1, 2'b10, 0, 1});

    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        step(tbl[i].rst, tbl[i].v, {64'h0, tbl[i].hdr});
        chk($sformatf("tbl%0d_slip", i), obs_slip, tbl[i].slip);
        chk($sformatf("tbl%0d_lock", i), lock, tbl[i].lock);
      end
    end

    // Locked: 15 bad per window tolerated, also across a window boundary
    step(1'b1, 1'b0, '0);
    good_words(64);
    slip_seen = 0;
    bad_words(15); good_words(49);
    good_words(49); bad_words(15);
    bad_words(15);
    chk("w15_lock", lock, 1'b1);
    chk("w15_noslip", slip_seen, 0);
    good_words(33);
    bad_words(1);                   // 16th bad in this window
    chk("w16_slip", obs_slip, 1'b1);
    chk("w16_lock", lock, 1'b0);
    chk("w16_count", slip_seen, 1);
    bad_words(1);                   // in wait: no second pulse
    chk("w16_noslip2", obs_slip, 1'b0);

    // 16th bad header on the 64th window word: loss wins
    step(1'b1, 1'b0, '0);
    good_words(64);
    good_words(48); bad_words(15);
    chk("edge_pre_lock", lock, 1'b1);
    bad_words(1);
    chk("edge_slip", obs_slip, 1'b1);
    chk("edge_lock", lock, 1'b0);

    // Loopback through a TX scrambler starting from zero
    step(1'b1, 1'b0, '0);
    tx_s = '0;
    begin
      logic [63:0] pl [4];
      logic [63:0] s;
      pl[0] = 64'h0123_4567_89AB_CDEF;
      pl[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      pl[2] = {$urandom, $urandom};
      pl[3] = {$urandom, $urandom};
      for (int i = 0; i < 64; i++) begin
        scramble(64'h0, s);
        step(1'b0, 1'b1, {s, 2'b10});
      end
      for (int i = 0; i < 4; i++) begin
        scramble(pl[i], s);
        step(1'b0, 1'b1, {s, 2'b10});
        chk($sformatf("loop%0d_data", i), dout, {pl[i], 2'b10});
        chk($sformatf("loop%0d_valid", i), ovld, 1'b1);
      end
    end

    // Reset while locked with a valid word present
    good_words(3);
    step(1'b1, 1'b1, {64'hDEAD_BEEF_0000_1111, 2'b01});
    chk("rst_lock", lock, 1'b0);
    chk("rst_valid", ovld, 1'b0);
    chk("rst_data", dout, 66'h0);
    good_words(63);
    chk("rst_hunt63", lock, 1'b0);
    good_words(1);
    chk("rst_hunt64", lock, 1'b1);

    // Misaligned serial stream: slip one bit per request until lock
    begin
      int  slips;
      bit  locked;
      int  drop;
      step(1'b1, 1'b0, '0);
      tx_s = '0;
      rxq.delete();
      gen_block();
      drop = $urandom_range(1, 65);
      repeat (drop) void'(rxq.pop_front());
      slips  = 0;
      locked = 1'b0;
      for (int w = 0; w < 6000 && !locked; w++) begin
        logic [65:0] word;
        while (rxq.size() < 67) gen_block();
        for (int k = 0; k < 66; k++) word[k] = rxq[k];
        repeat (66) void'(rxq.pop_front());
        step(1'b0, 1'b1, word);
        if (obs_slip) begin
          slips++;
          void'(rxq.pop_front());
        end
        locked = (lock === 1'b1);
      end
      chk("align_lock", locked, 1'b1);
      chk("align_slips_le66", slips <= 66, 1'b1);
      chk("align_slips_exact", slips, 66 - drop);
    end

    // Random traffic against the model, with bursty error rates
    step(1'b1, 1'b0, '0);
    begin
      int rate;
      for (int i = 0; i < 3000; i++) begin
        bit          r, v, bad;
        logic [1:0]  h;
        if (i % 100 == 0) begin
          case ($urandom_range(0, 3))
            0, 1: rate = 0;
            2:    rate = 2;
            default: rate = 35;
          endcase
        end
        r   = ($urandom_range(0, 499) == 0);
        v   = ($urandom_range(0, 99) < 85);
        bad = ($urandom_range(0, 99) < rate);
        if (bad) h = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        else     h = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        step(r, v, {$urandom, $urandom, h});
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
